// File: rtl/uncache_axi_bridge.sv
// Uncached load/store bridge: turns one captured uncache request into a
// single AXI read (AR/R) or write (AW+W/B) transaction, then pulses refresh.
module uncache_axi_bridge #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_e,
  input  logic        req_we,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wsel,
  output logic        refresh,
  output logic [63:0] rdata,
  output logic        err,
  output logic [63:0] araddr,
  output logic        arvalid,
  input  logic        arready,
  input  logic [63:0] r_data,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic        rready,
  output logic [63:0] awaddr,
  output logic        awvalid,
  input  logic        awready,
  output logic [63:0] wdata,
  output logic [7:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW_W, S_B, S_DONE} state_e;

  state_e        state_q, state_d;
  logic          armed_q, armed_d;
  logic [63:0]   addr_q, addr_d;
  logic [63:0]   wdata_q, wdata_d;
  logic [7:0]    wsel_q, wsel_d;
  logic          aw_done_q, aw_done_d;
  logic          w_done_q, w_done_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0]   rdata_q, rdata_d;
  logic          err_q, err_d;

  // Address/data come straight from the capture registers, which only change
  // in IDLE, so they are stable for as long as any valid is up.
  assign araddr = addr_q;
  assign awaddr = addr_q;
  assign wdata  = wdata_q;
  assign wstrb  = wsel_q;
  assign rdata  = rdata_q;
  assign err    = err_q;

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      armed_q   <= 1'b1;
      addr_q    <= '0;
      wdata_q   <= '0;
      wsel_q    <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      cnt_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      armed_q   <= armed_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wsel_q    <= wsel_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      cnt_q     <= cnt_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
    end
  end

  // Next-state and AXI handshake outputs.
  always_comb begin
    state_d   = state_q;
    // Any low cycle of req_e re-arms, so a level held across completion
    // cannot start a second transaction.
    armed_d   = armed_q | ~req_e;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wsel_d    = wsel_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    arvalid   = 1'b0;
    rready    = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    refresh   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_e && armed_q) begin
          armed_d   = 1'b0;
          addr_d    = req_addr;
          wdata_d   = req_wdata;
          wsel_d    = req_wsel;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = req_we ? S_AW_W : S_AR;
        end
      end
      S_AR: begin
        arvalid = 1'b1;
        if (arready) begin
          cnt_d   = '0;
          state_d = S_R;
        end
      end
      S_R: begin
        rready = 1'b1;
        // A response in the last allowed cycle wins over the timeout.
        if (rvalid) begin
          rdata_d = r_data;
          err_d   = |rresp;
          state_d = S_DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_AW_W: begin
        // AW and W retire independently; each valid falls the cycle after
        // its own handshake.
        awvalid = ~aw_done_q;
        wvalid  = ~w_done_q;
        if (awvalid && awready) aw_done_d = 1'b1;
        if (wvalid && wready)   w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) begin
          cnt_d   = '0;
          state_d = S_B;
        end
      end
      S_B: begin
        bready = 1'b1;
        if (bvalid) begin
          err_d   = |bresp;
          state_d = S_DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        refresh = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
